// File: rtl/crossbar_cfg_loader_if.sv
// crossbar_cfg_loader_if: valid/ready config beat stream feeding the crossbar config loader
interface crossbar_cfg_loader_if #(
    parameter int CFG_WIDTH = 32,
    parameter int CTX_W     = 2
);
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [CFG_WIDTH-1:0] cfg_data;
    logic                 cfg_last;
    logic [CTX_W-1:0]     cfg_ctx;
    modport master (output cfg_valid, cfg_data, cfg_last, cfg_ctx, input cfg_ready);
    modport slave  (input cfg_valid, cfg_data, cfg_last, cfg_ctx, output cfg_ready);
endinterface

// File: rtl/crossbar_cfg_loader.sv
// crossbar_cfg_loader: stages streamed select words, commits them into context slots, drives the active selects
module crossbar_cfg_loader #(
    parameter int NUM_INPUTS  = 14,
    parameter int NUM_OUTPUTS = 16,
    parameter int SEL_WIDTH   = $clog2(NUM_INPUTS),
    parameter int CFG_WIDTH   = 32,
    parameter int NUM_CTX     = 4,
    parameter int CTX_W       = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
    input  logic                                clk_gated,
    input  logic                                rst_n,
    crossbar_cfg_loader_if.slave                cfg,
    input  logic                                ctx_switch_i,
    input  logic [CTX_W-1:0]                    ctx_sel_i,
    output logic [NUM_OUTPUTS-1:0][SEL_WIDTH-1:0] select_o,
    output logic [CTX_W-1:0]                    active_ctx_o,
    output logic [NUM_CTX-1:0]                  ctx_valid_o,
    output logic                                busy_o,
    output logic                                done_o,
    output logic                                err_o,
    output logic [2:0]                          err_code_o
);
    localparam int OPW   = CFG_WIDTH / SEL_WIDTH;
    localparam int WORDS = (NUM_OUTPUTS + OPW - 1) / OPW;
    localparam int WCW   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [SEL_WIDTH:0] SEL_LIM = (SEL_WIDTH+1)'(NUM_INPUTS);

    typedef logic [NUM_OUTPUTS-1:0][SEL_WIDTH-1:0] sel_t;
    typedef enum logic [1:0] {IDLE, LOAD, COMMIT, DRAIN} state_t;

    state_t               state_q, state_d;
    logic [WCW-1:0]       word_cnt_q, word_cnt_d, k;
    logic [CTX_W-1:0]     tgt_q, active_q, active_d;
    sel_t                 stage_q, stage_d, select_q, select_d;
    sel_t                 ctx_mem_q [NUM_CTX];
    logic [NUM_CTX-1:0]   ctx_valid_q;
    logic [NUM_OUTPUTS-1:0] bad;
    logic                 accept, load_st, last_word;
    logic                 short_e, long_e, range_e, commit_ok, sw_ok, sw_err;
    logic                 done_q, err_q, err_d;
    logic [2:0]           err_code_q, err_code_d;

    assign cfg.cfg_ready = rst_n && state_q != COMMIT;
    assign accept        = cfg.cfg_valid && cfg.cfg_ready;
    assign load_st       = state_q == IDLE || state_q == LOAD;
    assign k             = (state_q == LOAD) ? word_cnt_q : '0;
    assign last_word     = k == WCW'(WORDS - 1);

    // Each output field is owned by exactly one beat; fields past NUM_OUTPUTS simply have no owner
    for (genvar i = 0; i < NUM_OUTPUTS; i++) begin : g_stage
        assign stage_d[i] = (accept && load_st && k == WCW'(i / OPW))
                          ? cfg.cfg_data[(i % OPW)*SEL_WIDTH +: SEL_WIDTH] : stage_q[i];
        assign bad[i]     = {1'b0, stage_q[i]} >= SEL_LIM;
    end

    // State register
    always_ff @(posedge clk_gated or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    // Next state: beat position and last flag decide commit, short/long abort or continue
    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        case (state_q)
            IDLE, LOAD: begin
                if (accept) begin
                    if (cfg.cfg_last) state_d = last_word ? COMMIT : IDLE;
                    else if (last_word) state_d = DRAIN;
                    else begin
                        state_d    = LOAD;
                        word_cnt_d = k + 1'b1;
                    end
                end
            end
            DRAIN:   state_d = (accept && cfg.cfg_last) ? IDLE : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: error classification, context switch and write-first select update
    always_comb begin
        short_e    = load_st && accept && cfg.cfg_last && !last_word;
        long_e     = load_st && accept && !cfg.cfg_last && last_word;
        range_e    = state_q == COMMIT && |bad;
        commit_ok  = state_q == COMMIT && !(|bad);
        sw_ok      = ctx_switch_i && ctx_valid_q[ctx_sel_i];
        sw_err     = ctx_switch_i && !ctx_valid_q[ctx_sel_i];
        err_d      = short_e || long_e || range_e || sw_err;
        err_code_d = range_e ? 3'd3 : short_e ? 3'd1 : long_e ? 3'd2 : sw_err ? 3'd4 : err_code_q;
        active_d   = sw_ok ? ctx_sel_i : active_q;
        select_d   = (commit_ok && tgt_q == active_d) ? stage_q
                   : sw_ok ? ctx_mem_q[ctx_sel_i] : select_q;
    end

    // Datapath registers: staging, context memory, active selects and status pulses
    always_ff @(posedge clk_gated or negedge rst_n) begin
        if (!rst_n) begin
            tgt_q       <= '0;
            stage_q     <= '0;
            ctx_mem_q   <= '{default: '0};
            ctx_valid_q <= NUM_CTX'(1);
            active_q    <= '0;
            select_q    <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= '0;
        end else begin
            if (accept && state_q == IDLE) tgt_q <= cfg.cfg_ctx;
            stage_q <= stage_d;
            if (commit_ok) begin
                ctx_mem_q[tgt_q]   <= stage_q;
                ctx_valid_q[tgt_q] <= 1'b1;
            end
            active_q   <= active_d;
            select_q   <= select_d;
            done_q     <= commit_ok;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign select_o     = select_q;
    assign active_ctx_o = active_q;
    assign ctx_valid_o  = ctx_valid_q;
    assign busy_o       = state_q != IDLE;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign err_code_o   = err_code_q;
endmodule

// File: tb/tb_crossbar_cfg_loader.sv
// tb_crossbar_cfg_loader: directed checks of load, commit, switch and error behaviour
module tb_crossbar_cfg_loader;
    logic                 clk_gated = 1'b0;
    logic                 rst_n;
    logic                 ctx_switch;
    logic [1:0]           ctx_sel;
    logic [15:0][3:0]     select;
    logic [1:0]           active_ctx;
    logic [3:0]           ctx_valid;
    logic                 busy, done, err;
    logic [2:0]           err_code;
    int                   n_checks = 0;
    int                   n_errors = 0;

    crossbar_cfg_loader_if #(.CFG_WIDTH(32), .CTX_W(2)) bus ();

    crossbar_cfg_loader dut (
        .clk_gated    (clk_gated),
        .rst_n        (rst_n),
        .cfg          (bus),
        .ctx_switch_i (ctx_switch),
        .ctx_sel_i    (ctx_sel),
        .select_o     (select),
        .active_ctx_o (active_ctx),
        .ctx_valid_o  (ctx_valid),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err),
        .err_code_o   (err_code)
    );

    always #5 clk_gated = ~clk_gated;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_gated);
        #1;
    endtask

    task automatic beat(input logic [31:0] d, input logic l, input logic [1:0] c);
        int n;
        bus.cfg_data  = d;
        bus.cfg_last  = l;
        bus.cfg_ctx   = c;
        bus.cfg_valid = 1'b1;
        n = 0;
        while (!bus.cfg_ready && n < 20) begin
            tick;
            n++;
        end
        check("beat_ready_timeout", n < 20, 1'b1);
        tick;
    endtask

    task automatic idle;
        bus.cfg_valid = 1'b0;
        bus.cfg_last  = 1'b0;
    endtask

    task automatic switch_to(input logic [1:0] s);
        ctx_switch = 1'b1;
        ctx_sel    = s;
        tick;
        ctx_switch = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        ctx_switch = 1'b0;
        ctx_sel = '0;
        bus.cfg_valid = 1'b0;
        bus.cfg_data = '0;
        bus.cfg_last = 1'b0;
        bus.cfg_ctx = '0;
        tick;
        tick;
        check("ready_in_reset", bus.cfg_ready, 1'b0);
        rst_n = 1'b1;
        tick;
        check("rst_select", select, 64'h0);
        check("rst_active", active_ctx, 2'd0);
        check("rst_ctx_valid", ctx_valid, 4'b0001);
        check("rst_ready", bus.cfg_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_err_code", err_code, 3'd0);
        // Load ctx1 while ctx0 is active
        beat(32'h76543210, 1'b0, 2'd1);
        check("load_busy", busy, 1'b1);
        beat(32'hDCBA9876, 1'b1, 2'd1);
        idle;
        check("commit_ready_low", bus.cfg_ready, 1'b0);
        tick;
        check("ld1_done", done, 1'b1);
        check("ld1_err", err, 1'b0);
        check("ld1_valid", ctx_valid, 4'b0011);
        check("ld1_select_unchanged", select, 64'h0);
        tick;
        check("done_pulse", done, 1'b0);
        switch_to(2'd1);
        check("sw1_active", active_ctx, 2'd1);
        check("sw1_select", select, 64'hDCBA9876_76543210);
        // Out-of-range select field
        beat(32'h0000000E, 1'b0, 2'd2);
        beat(32'h00000000, 1'b1, 2'd2);
        idle;
        tick;
        check("range_err", err, 1'b1);
        check("range_code", err_code, 3'd3);
        check("range_done", done, 1'b0);
        check("range_valid", ctx_valid, 4'b0011);
        check("range_select", select, 64'hDCBA9876_76543210);
        switch_to(2'd2);
        check("sw2_err", err, 1'b1);
        check("sw2_code", err_code, 3'd4);
        check("sw2_active", active_ctx, 2'd1);
        tick;
        check("err_pulse", err, 1'b0);
        check("code_held", err_code, 3'd4);
        // Short load
        beat(32'h00000001, 1'b1, 2'd3);
        idle;
        check("short_err", err, 1'b1);
        check("short_code", err_code, 3'd1);
        check("short_idle", busy, 1'b0);
        // Long load, drained, then a good load
        beat(32'h11111111, 1'b0, 2'd3);
        beat(32'h22222222, 1'b0, 2'd3);
        check("long_err", err, 1'b1);
        check("long_code", err_code, 3'd2);
        check("long_drain_busy", busy, 1'b1);
        beat(32'h33333333, 1'b1, 2'd3);
        idle;
        check("drain_done_err", err, 1'b0);
        check("drain_idle", busy, 1'b0);
        check("drain_valid", ctx_valid, 4'b0011);
        beat(32'h01234567, 1'b0, 2'd3);
        beat(32'h0D0D0D0D, 1'b1, 2'd3);
        idle;
        tick;
        check("ld3_done", done, 1'b1);
        check("ld3_valid", ctx_valid, 4'b1011);
        check("ld3_select", select, 64'hDCBA9876_76543210);
        // Back-to-back loads to the active context with valid held high
        repeat ($urandom_range(0, 3)) tick;
        bus.cfg_valid = 1'b1;
        bus.cfg_ctx   = 2'd1;
        bus.cfg_last  = 1'b0;
        bus.cfg_data  = 32'h10213243;
        tick;
        bus.cfg_last  = 1'b1;
        bus.cfg_data  = 32'h54657687;
        tick;
        check("bp_ready_low", bus.cfg_ready, 1'b0);
        check("bp_select_hold", select, 64'hDCBA9876_76543210);
        bus.cfg_last  = 1'b0;
        bus.cfg_data  = 32'hDDDDDDDD;
        tick;
        check("bp_commit_select", select, 64'h54657687_10213243);
        check("bp_done", done, 1'b1);
        tick;
        bus.cfg_last  = 1'b1;
        bus.cfg_data  = 32'h00000000;
        tick;
        idle;
        tick;
        check("bp2_select", select, 64'h00000000_DDDDDDDD);
        check("bp2_done", done, 1'b1);
        // Switch coinciding with commit to the new active slot
        beat(32'h33333333, 1'b0, 2'd3);
        beat(32'h44444444, 1'b1, 2'd3);
        idle;
        switch_to(2'd3);
        check("wf_active", active_ctx, 2'd3);
        check("wf_select", select, 64'h44444444_33333333);
        check("wf_done", done, 1'b1);
        // Switch to a slot being committed for the first time
        beat(32'h01010101, 1'b0, 2'd2);
        beat(32'h02020202, 1'b1, 2'd2);
        idle;
        switch_to(2'd2);
        check("first_sw_err", err, 1'b1);
        check("first_sw_code", err_code, 3'd4);
        check("first_sw_done", done, 1'b1);
        check("first_sw_active", active_ctx, 2'd3);
        check("first_sw_valid", ctx_valid, 4'b1111);
        check("first_sw_select", select, 64'h44444444_33333333);
        // Reset in the middle of a load
        beat(32'h0000000C, 1'b0, 2'd1);
        idle;
        check("mid_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", bus.cfg_ready, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_valid", ctx_valid, 4'b0001);
        check("mid_rst_select", select, 64'h0);
        check("mid_rst_active", active_ctx, 2'd0);
        tick;
        rst_n = 1'b1;
        tick;
        check("post_rst_ready", bus.cfg_ready, 1'b1);
        switch_to(2'd1);
        check("post_rst_sw_code", err_code, 3'd4);
        check("post_rst_active", active_ctx, 2'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
